// File: rtl/gpio_pat_seq_if.sv
`default_nettype none
// ============================================================================
// Interface : gpio_pat_seq_if
// Host-side entry write handshake for the GPIO pattern sequencer.
// Revision  : 1.0
// ============================================================================
interface gpio_pat_seq_if #(
    parameter int PIN_NUM   = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 wr_valid_i;
    logic                 wr_ready_o;
    logic [PIN_NUM-1:0]   wr_pat_i;
    logic [PIN_NUM-1:0]   wr_dir_i;
    logic [CNT_WIDTH-1:0] wr_dly_i;

    modport master (
        output wr_valid_i,
        output wr_pat_i,
        output wr_dir_i,
        output wr_dly_i,
        input  wr_ready_o
    );

    modport slave (
        input  wr_valid_i,
        input  wr_pat_i,
        input  wr_dir_i,
        input  wr_dly_i,
        output wr_ready_o
    );
endinterface
`default_nettype wire

// File: rtl/gpio_pat_seq.sv
`default_nettype none
// ============================================================================
// Module   : gpio_pat_seq
// Plays stored, timed out/dir patterns on the GPIO alternate-function path.
// Revision : 1.0
// ============================================================================
module gpio_pat_seq #(
    parameter int PIN_NUM   = 32,
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  wire                        pclk,
    input  wire                        presetn,
    gpio_pat_seq_if.slave              wr,
    input  wire                        clear_i,
    input  wire                        start_i,
    input  wire                        stop_i,
    input  wire                        loop_i,
    output logic [PIN_NUM-1:0]         alt_out_o,
    output logic [PIN_NUM-1:0]         alt_dir_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [$clog2(DEPTH)-1:0]   idx_o,
    output logic [$clog2(DEPTH):0]     cnt_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_next;
    logic [CNT_WIDTH-1:0] timer;
    logic                 loop_flag;

    logic [PIN_NUM-1:0]   pat_mem [DEPTH];
    logic [PIN_NUM-1:0]   dir_mem [DEPTH];
    logic [CNT_WIDTH-1:0] dly_mem [DEPTH];

    logic                 wr_ready;
    logic                 wr_fire;
    logic                 start_ok;
    logic                 at_last;

    // Ready is gated by presetn so the host never sees an accept during reset.
    assign wr_ready      = presetn && (state == IDLE) && (cnt < CNT_W'(DEPTH)) && !clear_i;
    assign wr.wr_ready_o = wr_ready;
    assign wr_fire       = wr.wr_valid_i && wr_ready;
    assign start_ok      = start_i && !stop_i && !clear_i && (cnt != '0);
    assign at_last       = ({1'b0, idx} == (cnt - CNT_W'(1)));
    assign idx_next      = idx + IDX_W'(1);

    assign idx_o = idx;
    assign cnt_o = cnt;

    always_ff @(posedge pclk) begin
        if (wr_fire) begin
            pat_mem[cnt[IDX_W-1:0]] <= wr.wr_pat_i;
            dir_mem[cnt[IDX_W-1:0]] <= wr.wr_dir_i;
            dly_mem[cnt[IDX_W-1:0]] <= wr.wr_dly_i;
        end
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            timer     <= '0;
            loop_flag <= 1'b0;
            alt_out_o <= '0;
            alt_dir_o <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_i) begin
                        cnt <= '0;
                    end else if (wr_fire) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    if (start_ok) begin
                        state     <= RUN;
                        busy_o    <= 1'b1;
                        idx       <= '0;
                        timer     <= dly_mem[0];
                        loop_flag <= loop_i;
                        alt_out_o <= pat_mem[0];
                        alt_dir_o <= dir_mem[0];
                    end
                end
                RUN: begin
                    // Stop wins over expiry; outputs and index freeze where they are.
                    if (stop_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else if (timer != '0) begin
                        timer <= timer - CNT_WIDTH'(1);
                    end else if (!at_last) begin
                        idx       <= idx_next;
                        timer     <= dly_mem[idx_next];
                        alt_out_o <= pat_mem[idx_next];
                        alt_dir_o <= dir_mem[idx_next];
                    end else if (loop_flag) begin
                        idx       <= '0;
                        timer     <= dly_mem[0];
                        alt_out_o <= pat_mem[0];
                        alt_dir_o <= dir_mem[0];
                    end else begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gpio_pat_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_pat_seq
// Directed bench for gpio_pat_seq with a timeline-expansion reference model.
// Revision : 1.0
// ============================================================================
module tb_gpio_pat_seq;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        clear_i = 1'b0;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic        loop_i = 1'b0;
    logic [31:0] alt_out_o;
    logic [31:0] alt_dir_o;
    logic        busy_o;
    logic        done_o;
    logic [2:0]  idx_o;
    logic [3:0]  cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    gpio_pat_seq_if #(.PIN_NUM(32), .CNT_WIDTH(16)) bus ();

    gpio_pat_seq #(.PIN_NUM(32), .DEPTH(8), .CNT_WIDTH(16)) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .wr        (bus.slave),
        .clear_i   (clear_i),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .loop_i    (loop_i),
        .alt_out_o (alt_out_o),
        .alt_dir_o (alt_dir_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .idx_o     (idx_o),
        .cnt_o     (cnt_o)
    );

    always #5 pclk = ~pclk;

    // Reference model: a playback is unrolled into one frame per output cycle.
    typedef struct packed {
        logic [31:0] pat;
        logic [31:0] dir;
        logic [2:0]  idx;
    } frame_t;

    frame_t      frames[$];
    logic [31:0] m_pat [8];
    logic [31:0] m_dir [8];
    logic [15:0] m_dly [8];
    int          m_cnt = 0;
    int          m_idx = 0;
    bit          m_busy = 0;
    bit          m_done = 0;
    bit          m_loop = 0;
    bit          m_rdy = 0;
    bit          edge_seen = 0;
    logic [31:0] m_out = '0;
    logic [31:0] m_odir = '0;

    function automatic void expand_pass();
        for (int k = 0; k < m_cnt; k++)
            for (int r = 0; r <= int'(m_dly[k]); r++)
                frames.push_back('{pat: m_pat[k], dir: m_dir[k], idx: 3'(k)});
    endfunction

    function automatic void show_next();
        frame_t f;
        f      = frames.pop_front();
        m_out  = f.pat;
        m_odir = f.dir;
        m_idx  = int'(f.idx);
    endfunction

    always @(posedge pclk) begin
        edge_seen = 1;
        if (!presetn) begin
            m_cnt = 0; m_idx = 0; m_busy = 0; m_done = 0; m_loop = 0;
            m_out = '0; m_odir = '0;
            frames.delete();
        end else begin
            m_done = 0;
            if (!m_busy) begin
                m_rdy = (m_cnt < 8) && !clear_i;
                if (start_i && !stop_i && !clear_i && m_cnt != 0) begin
                    m_loop = loop_i;
                    m_busy = 1;
                    expand_pass();
                    show_next();
                end
                if (clear_i) begin
                    m_cnt = 0;
                end else if (bus.wr_valid_i && m_rdy) begin
                    m_pat[m_cnt] = bus.wr_pat_i;
                    m_dir[m_cnt] = bus.wr_dir_i;
                    m_dly[m_cnt] = bus.wr_dly_i;
                    m_cnt++;
                end
            end else if (stop_i) begin
                m_busy = 0;
                frames.delete();
            end else if (frames.size() != 0) begin
                show_next();
            end else if (m_loop) begin
                expand_pass();
                show_next();
            end else begin
                m_busy = 0;
                m_done = 1;
            end
        end
    end

    logic [73:0] exp_v;
    logic [73:0] act_v;

    always @(negedge pclk) begin
        if (edge_seen) begin
            exp_v = {m_out, m_odir, m_busy, m_done, 3'(m_idx), 4'(m_cnt),
                     presetn && !m_busy && (m_cnt < 8) && !clear_i};
            act_v = {alt_out_o, alt_dir_o, busy_o, done_o, idx_o, cnt_o, bus.wr_ready_o};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL cycle_state t=%0t got %h want %h", $time, act_v, exp_v);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic wr(input logic [31:0] p, input logic [31:0] d, input logic [15:0] l);
        bus.wr_valid_i = 1'b1;
        bus.wr_pat_i   = p;
        bus.wr_dir_i   = d;
        bus.wr_dly_i   = l;
        step();
        bus.wr_valid_i = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [31:0] seq1 [5] = '{32'h1, 32'h2, 32'h2, 32'h2, 32'h4};
    logic [31:0] seq3 [6] = '{32'h1, 32'h1, 32'h2, 32'h2, 32'h1, 32'h1};
    int n;

    initial begin
        bus.wr_valid_i = 1'b0;
        bus.wr_pat_i   = '0;
        bus.wr_dir_i   = '0;
        bus.wr_dly_i   = '0;

        // Reset and basic three-entry playback
        repeat (3) step();
        @(negedge pclk);
        check("rst_out", alt_out_o, 32'h0);
        check("rst_cnt", cnt_o, 32'h0);
        check("rst_busy", busy_o, 32'h0);
        check("rst_ready", bus.wr_ready_o, 32'h0);
        step();
        presetn = 1'b1;
        wr(32'h1, 32'h1, 16'd0);
        wr(32'h2, 32'h3, 16'd2);
        wr(32'h4, 32'h7, 16'd0);
        @(negedge pclk);
        check("wr_cnt3", cnt_o, 32'd3);
        step();
        start_i = 1'b1; loop_i = 1'b0;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            check($sformatf("seq1_out[%0d]", i), alt_out_o, seq1[i]);
            check($sformatf("seq1_busy[%0d]", i), busy_o, 32'h1);
            step();
        end
        @(negedge pclk);
        check("seq1_done", done_o, 32'h1);
        check("seq1_busy_fall", busy_o, 32'h0);
        check("seq1_hold", alt_out_o, 32'h4);
        step();
        @(negedge pclk);
        check("seq1_done_once", done_o, 32'h0);

        // Full buffer
        step();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        @(negedge pclk);
        check("clr_cnt", cnt_o, 32'h0);
        for (int i = 0; i < 8; i++) wr(32'h10 + 32'(i), 32'hFFFF_FFFF, 16'd0);
        bus.wr_valid_i = 1'b1; bus.wr_pat_i = 32'hDEAD;
        @(negedge pclk);
        check("full_ready", bus.wr_ready_o, 32'h0);
        step(); step();
        bus.wr_valid_i = 1'b0;
        @(negedge pclk);
        check("full_cnt", cnt_o, 32'd8);
        step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge pclk);
            check($sformatf("full_out[%0d]", i), alt_out_o, 32'h10 + 32'(i));
            step();
        end
        @(negedge pclk);
        check("full_done", done_o, 32'h1);

        // Loop then stop in the 7th RUN cycle
        step();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        wr(32'h1, 32'h1, 16'd1);
        wr(32'h2, 32'h3, 16'd1);
        start_i = 1'b1; loop_i = 1'b1;
        step();
        start_i = 1'b0; loop_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge pclk);
            check($sformatf("loop_out[%0d]", i), alt_out_o, seq3[i]);
            step();
        end
        stop_i = 1'b1;
        @(negedge pclk);
        check("loop_c7_busy", busy_o, 32'h1);
        step();
        stop_i = 1'b0;
        @(negedge pclk);
        check("stop_busy", busy_o, 32'h0);
        check("stop_done", done_o, 32'h0);
        check("stop_hold", alt_out_o, 32'h2);
        step(); step();
        @(negedge pclk);
        check("stop_hold_later", alt_out_o, 32'h2);

        // Ignored commands
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        @(negedge pclk);
        check("empty_start_busy", busy_o, 32'h0);
        check("empty_start_done", done_o, 32'h0);
        step();
        @(negedge pclk);
        check("empty_start_done2", done_o, 32'h0);
        wr(32'hA5, 32'hFF, 16'd3);
        start_i = 1'b1; stop_i = 1'b1;
        step();
        start_i = 1'b0; stop_i = 1'b0;
        @(negedge pclk);
        check("start_stop_busy", busy_o, 32'h0);
        step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        clear_i = 1'b1;
        bus.wr_valid_i = 1'b1; bus.wr_pat_i = 32'hBAD;
        @(negedge pclk);
        check("run_ready", bus.wr_ready_o, 32'h0);
        step();
        clear_i = 1'b0;
        bus.wr_valid_i = 1'b0;
        @(negedge pclk);
        check("run_clear_cnt", cnt_o, 32'd1);
        check("run_clear_busy", busy_o, 32'h1);
        n = 0;
        while (!done_o && n < 20) begin
            step();
            @(negedge pclk);
            n++;
        end
        check("ignored_done", done_o, 32'h1);

        // Mid-playback reset
        step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        presetn = 1'b0;
        step();
        @(negedge pclk);
        check("mrst_out", alt_out_o, 32'h0);
        check("mrst_dir", alt_dir_o, 32'h0);
        check("mrst_cnt", cnt_o, 32'h0);
        check("mrst_busy", busy_o, 32'h0);
        step();
        presetn = 1'b1;

        // Long hold
        wr(32'h5A5A, 32'hFFFF_FFFF, 16'hFFFF);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        n = 0;
        @(negedge pclk);
        while (busy_o && n < 70000) begin
            n++;
            step();
            @(negedge pclk);
        end
        check("long_len", 32'(n), 32'd65536);
        check("long_done", done_o, 32'h1);
        check("long_hold", alt_out_o, 32'h5A5A);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpio_pat_seq.md
# gpio_pat_seq

Programmable pattern sequencer for the GPIO alternate-function path. It stores up to DEPTH timed output/direction patterns loaded by a host-side write handshake. On command it plays them out on its registered outputs, once or looping. The outputs are wired to the GPIO block's alt-0 (or alt-1) out/dir inputs, so a pin set to IOF mode is driven by this sequence without CPU involvement.

## Interface
- PIN_NUM, 32: pattern width, matching the GPIO pin count.
- DEPTH, 8: number of pattern entries; power of two, at least 2.
- CNT_WIDTH, 16: width of the per-entry hold count.

- pclk  in  1  clock.
- presetn  in  1  reset; synchronous, active-low.
- wr_valid_i  in  1  entry write request.
- wr_ready_o  out  1  entry write accept.
- wr_pat_i  in  PIN_NUM  output pattern of the entry.
- wr_dir_i  in  PIN_NUM  direction pattern of the entry; 1 = output.
- wr_dly_i  in  CNT_WIDTH  hold count of the entry; the entry lasts wr_dly_i+1 cycles.
- clear_i  in  1  empty the entry buffer.
- start_i  in  1  begin playback.
- stop_i  in  1  abort playback.
- loop_i  in  1  loop mode; sampled on the start cycle only.
- alt_out_o  out  PIN_NUM  registered pattern output.
- alt_dir_o  out  PIN_NUM  registered direction output.
- busy_o  out  1  high while in RUN.
- done_o  out  1  one-cycle pulse on normal completion.
- idx_o  out  $clog2(DEPTH)  index of the entry currently playing.
- cnt_o  out  $clog2(DEPTH)+1  number of stored entries.

## Operation
- Storage: DEPTH-entry array of {pat, dir, dly}, a write pointer equal to cnt, an index, and a down-counter timer.
- Reset state: state=IDLE, cnt=0, idx=0, timer=0, loop flag=0.
- Reset values of outputs: alt_out_o=0, alt_dir_o=0, busy_o=0, done_o=0, idx_o=0, cnt_o=0, wr_ready_o=0 while presetn is low.
- Write path:
  - wr_ready_o = (state==IDLE) & (cnt<DEPTH) & ~clear_i.
  - When valid and ready are both high, the entry is stored at array[cnt] and cnt increments.
- clear_i in IDLE sets cnt=0. clear_i in RUN is ignored.
- IDLE -> RUN when start_i & ~stop_i & ~clear_i & (cnt!=0). On that edge:
  - idx=0, timer=dly[0], loop flag=loop_i.
  - alt_out_o/alt_dir_o load pat[0]/dir[0].
- start_i with cnt==0 is ignored: no state change, no done pulse.
- RUN behaviour:
  - Each cycle, if timer!=0 then timer decrements.
  - If timer==0 and idx!=cnt-1: idx increments, timer=dly[idx+1], and the outputs load entry idx+1.
  - If timer==0, idx==cnt-1 and the loop flag is set: idx=0, timer=dly[0], and the outputs load entry 0.
  - If timer==0, idx==cnt-1 and the loop flag is clear: go to IDLE and pulse done_o.
- stop_i in RUN: go to IDLE on the next edge. The outputs hold the value they have at that edge, and done_o is not pulsed. stop_i has priority over the timer-expiry transition in the same cycle.
- Output levels in IDLE: alt_out_o/alt_dir_o hold the last driven entry. They are not cleared by clear_i.
- start_i in RUN is ignored; there is no restart.
- Stored entries persist across playbacks until clear_i or reset.
- A synchronous reset in the middle of playback returns every register to its reset value on that edge.

## Timing
- start_i high in cycle T gives, in cycle T+1: busy_o=1, idx_o=0, alt_out_o=pat[0].
- Entry k first appears in cycle T+1+Σ_{j<k}(dly_j+1) and is held for exactly dly_k+1 cycles.
- Non-loop completion: done_o=1 and busy_o=0 in the cycle after the last cycle of entry cnt-1.
- Loop wrap: entry 0 follows entry cnt-1 with no gap cycle.
- stop_i high in cycle S gives busy_o=0 in cycle S+1.
- One write is accepted per cycle, giving back-to-back throughput. The write accepted in cycle W is visible on cnt_o in W+1.
- All outputs are registered except wr_ready_o, which is combinational from the state, cnt and clear_i.

## Test plan
- Reset and write flow: reset, then write 3 entries {0x1,0x1,0}, {0x2,0x3,2}, {0x4,0x7,0}, then start with loop_i=0.
  - Required: alt_out_o = 0x1 for 1 cycle, 0x2 for 3 cycles, 0x4 for 1 cycle.
  - Then done_o pulses once in the following cycle and busy_o falls.
- Full buffer: write 8 entries, then hold wr_valid_i for a 9th.
  - Required: wr_ready_o=0 and cnt_o=8, and the 9th entry is not stored.
- Loop and stop: 2 entries with dly=1, start with loop_i=1, assert stop_i in the 7th RUN cycle.
  - Required: the sequence 0x1,0x1,0x2,0x2,0x1,0x1 then stop; busy_o falls in the next cycle.
  - alt_out_o holds its value, and done_o never pulses.
- Ignored commands:
  - start with cnt=0 leaves state IDLE with no pulse.
  - clear_i in RUN leaves cnt_o unchanged.
  - start_i with stop_i in the same IDLE cycle keeps busy_o low.
  - A write during RUN sees wr_ready_o=0.
- Mid-playback reset: presetn low during RUN gives alt_out_o=0, alt_dir_o=0, cnt_o=0, busy_o=0 on the next edge.
- Long hold: a single entry with dly=0xFFFF keeps its output for exactly 65536 cycles, followed by done_o.
